// File: rtl/edge_pe_fv_req_router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edge_pe_fv_req_router_pkg
// Purpose  : Shared sizes and request/packet types for the Edge PE -> FV router.
// Revision : 1.0
// ============================================================================
package edge_pe_fv_req_router_pkg;

  localparam int NUM_EDGE_PE      = 4;
  localparam int NUM_BANKS_ALL_FV = 4;
  localparam int MAX_NODE_ID      = 64;
  localparam int NODE_W           = $clog2(MAX_NODE_ID);
  localparam int FV_BANDWIDTH     = 32;
  localparam int DATA_W           = FV_BANDWIDTH;
  localparam int PE_TAG_W         = $clog2(NUM_EDGE_PE);

  typedef struct packed {
    logic              valid;
    logic              rd_wr;
    logic [NODE_W-1:0] Node_id;
    logic [DATA_W-1:0] data;
    logic              wr_sos;
    logic              wr_eos;
  } Edge_PE2FV_req;

  typedef struct packed {
    logic                valid;
    logic [PE_TAG_W-1:0] PE_tag;
    logic                rd_wr;
    logic [NODE_W-1:0]   Node_id;
    logic [DATA_W-1:0]   data;
    logic                wr_sos;
    logic                wr_eos;
  } Req2Output_SRAM_Bank;

  function automatic Req2Output_SRAM_Bank make_pkt(input Edge_PE2FV_req r,
                                                   input logic [PE_TAG_W-1:0] tag);
    Req2Output_SRAM_Bank pkt;
    pkt.valid   = 1'b1;
    pkt.PE_tag  = tag;
    pkt.rd_wr   = r.rd_wr;
    pkt.Node_id = r.Node_id;
    pkt.data    = r.data;
    pkt.wr_sos  = r.wr_sos;
    pkt.wr_eos  = r.wr_eos;
    return pkt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_pe_fv_req_router_if.sv
`default_nettype none
// ============================================================================
// Module   : edge_pe_fv_req_router_if
// Purpose  : PE request bus and bank-controller packet bus of the FV router.
// Revision : 1.0
// ============================================================================
interface edge_pe_fv_req_router_if
  import edge_pe_fv_req_router_pkg::*;
#(
  parameter int NUM_PE   = NUM_EDGE_PE,
  parameter int NUM_BANK = NUM_BANKS_ALL_FV
);
  Edge_PE2FV_req       [NUM_PE-1:0]   pe_req;
  logic                [NUM_PE-1:0]   pe_req_ready;
  logic                [NUM_BANK-1:0] bank_available;
  Req2Output_SRAM_Bank [NUM_BANK-1:0] req_pkt;
  logic                [NUM_BANK-1:0] bank_locked;

  modport master (
    output pe_req, bank_available,
    input  pe_req_ready, req_pkt, bank_locked
  );

  modport slave (
    input  pe_req, bank_available,
    output pe_req_ready, req_pkt, bank_locked
  );
endinterface
`default_nettype wire

// File: rtl/edge_pe_fv_req_router_fv_bank_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fv_bank_rr_arbiter
// Purpose  : Per-bank round-robin arbiter with write-stream lock ownership.
// Revision : 1.0
// ============================================================================
module fv_bank_rr_arbiter #(
  parameter int NUM_PE = 4,
  parameter int PTR_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic [NUM_PE-1:0] i_req,
  input  wire logic [NUM_PE-1:0] i_wr,
  input  wire logic [NUM_PE-1:0] i_sos,
  input  wire logic [NUM_PE-1:0] i_eos,
  input  wire logic              i_available,
  output logic      [NUM_PE-1:0] o_grant,
  output logic                   o_found,
  output logic      [PTR_W-1:0]  o_gnt_idx,
  output logic                   o_locked
);

  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_owner;
  logic              r_locked;
  logic [NUM_PE-1:0] w_elig;
  logic [PTR_W-1:0]  w_sel;
  int                w_j;

  // Holding reset low masks every request, so ready stays low during reset.
  always_comb begin
    w_elig    = '0;
    o_grant   = '0;
    o_found   = 1'b0;
    o_gnt_idx = '0;
    w_j       = 0;
    w_sel     = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      w_elig[p] = reset && i_available && i_req[p] &&
                  (!r_locked || (r_owner == PTR_W'(p)));
    end
    for (int i = 0; i < NUM_PE; i++) begin
      w_j = int'(r_ptr) + i;
      if (w_j >= NUM_PE) w_j = w_j - NUM_PE;
      w_sel = PTR_W'(w_j);
      if (!o_found && w_elig[w_sel]) begin
        o_found        = 1'b1;
        o_grant[w_sel] = 1'b1;
        o_gnt_idx      = w_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr    <= '0;
      r_locked <= 1'b0;
      r_owner  <= '0;
    end else if (o_found) begin
      r_ptr <= (o_gnt_idx == PTR_W'(NUM_PE - 1)) ? '0 : o_gnt_idx + PTR_W'(1);
      // Only the owner can be granted while locked, so eos here is always the owner's.
      if (i_wr[o_gnt_idx]) begin
        if (i_sos[o_gnt_idx] && !i_eos[o_gnt_idx]) begin
          r_locked <= 1'b1;
          r_owner  <= o_gnt_idx;
        end else if (r_locked && i_eos[o_gnt_idx]) begin
          r_locked <= 1'b0;
        end
      end
    end
  end

  assign o_locked = r_locked;

endmodule
`default_nettype wire

// File: rtl/edge_pe_fv_req_router.sv
`default_nettype none
// ============================================================================
// Module   : edge_pe_fv_req_router
// Purpose  : Routes Edge PE FV requests to banks by Node_id; registers packets.
// Revision : 1.0
// ============================================================================
module edge_pe_fv_req_router
  import edge_pe_fv_req_router_pkg::*;
#(
  parameter int NUM_PE   = NUM_EDGE_PE,
  parameter int NUM_BANK = NUM_BANKS_ALL_FV
) (
  input  wire logic               clk,
  input  wire logic               reset,
  edge_pe_fv_req_router_if.slave  bus
);

  localparam int BANK_W = $clog2(NUM_BANK);
  localparam int PTR_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic [NUM_PE-1:0] w_grant [NUM_BANK];
  logic [NUM_PE-1:0] w_ready;

  genvar b;
  generate
    for (b = 0; b < NUM_BANK; b++) begin : g_bank
      localparam logic [BANK_W-1:0] c_bank = BANK_W'(b);

      logic [NUM_PE-1:0]   w_req;
      logic [NUM_PE-1:0]   w_wr;
      logic [NUM_PE-1:0]   w_sos;
      logic [NUM_PE-1:0]   w_eos;
      logic                w_found;
      logic [PTR_W-1:0]    w_gnt_idx;
      logic                w_locked;
      Req2Output_SRAM_Bank r_pkt;

      always_comb begin
        w_req = '0;
        w_wr  = '0;
        w_sos = '0;
        w_eos = '0;
        for (int p = 0; p < NUM_PE; p++) begin
          w_req[p] = bus.pe_req[p].valid &&
                     (bus.pe_req[p].Node_id[BANK_W-1:0] == c_bank);
          w_wr[p]  = bus.pe_req[p].rd_wr;
          w_sos[p] = bus.pe_req[p].wr_sos;
          w_eos[p] = bus.pe_req[p].wr_eos;
        end
      end

      fv_bank_rr_arbiter #(
        .NUM_PE (NUM_PE),
        .PTR_W  (PTR_W)
      ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_req       (w_req),
        .i_wr        (w_wr),
        .i_sos       (w_sos),
        .i_eos       (w_eos),
        .i_available (bus.bank_available[b]),
        .o_grant     (w_grant[b]),
        .o_found     (w_found),
        .o_gnt_idx   (w_gnt_idx),
        .o_locked    (w_locked)
      );

      // Payload fields hold their last value when no grant lands here.
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_pkt <= '0;
        end else if (w_found) begin
          r_pkt <= make_pkt(bus.pe_req[w_gnt_idx], PE_TAG_W'(w_gnt_idx));
        end else begin
          r_pkt.valid <= 1'b0;
        end
      end

      assign bus.req_pkt[b]     = r_pkt;
      assign bus.bank_locked[b] = w_locked;
    end
  endgenerate

  always_comb begin
    w_ready = '0;
    for (int k = 0; k < NUM_BANK; k++) begin
      w_ready = w_ready | w_grant[k];
    end
  end

  assign bus.pe_req_ready = w_ready;

endmodule
`default_nettype wire

// File: tb/tb_edge_pe_fv_req_router.sv
`default_nettype none
// Directed bench for edge_pe_fv_req_router: a per-cycle reference model of the
// routing/lock rules plus hand-computed expectations for each scenario.
module tb_edge_pe_fv_req_router;
  import edge_pe_fv_req_router_pkg::*;

  localparam int NP = 4;
  localparam int NB = 4;

  logic clk;
  logic reset;
  bit   chk_en;
  int   n_checks;
  int   n_err;

  edge_pe_fv_req_router_if #(.NUM_PE(NP), .NUM_BANK(NB)) u_if ();

  edge_pe_fv_req_router #(.NUM_PE(NP), .NUM_BANK(NB)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: state per bank, advanced at each negedge for the next posedge.
  int                  m_ptr   [NB];
  bit                  m_lock  [NB];
  int                  m_owner [NB];
  Req2Output_SRAM_Bank m_pkt   [NB];

  initial begin
    for (int b = 0; b < NB; b++) begin
      m_ptr[b] = 0; m_lock[b] = 0; m_owner[b] = 0; m_pkt[b] = '0;
    end
  end

  always @(negedge clk) begin
    logic [NP-1:0] e_ready;
    int            g [NB];
    int            p;
    Edge_PE2FV_req r;
    e_ready = '0;
    for (int b = 0; b < NB; b++) begin
      g[b] = -1;
      if (reset) begin
        for (int o = 0; o < NP; o++) begin
          p = (m_ptr[b] + o) % NP;
          r = u_if.pe_req[p];
          if (g[b] < 0 && r.valid && (int'(r.Node_id) % NB) == b &&
              u_if.bank_available[b] && (!m_lock[b] || m_owner[b] == p))
            g[b] = p;
        end
      end
      if (g[b] >= 0) e_ready[g[b]] = 1'b1;
    end
    if (chk_en) begin
      chk("model_ready", 64'(u_if.pe_req_ready), 64'(e_ready));
      for (int b = 0; b < NB; b++) begin
        chk($sformatf("model_locked[%0d]", b), 64'(u_if.bank_locked[b]), 64'(m_lock[b]));
        chk($sformatf("model_pkt[%0d]", b), 64'(u_if.req_pkt[b]), 64'(m_pkt[b]));
      end
    end
    for (int b = 0; b < NB; b++) begin
      if (!reset) begin
        m_ptr[b] = 0; m_lock[b] = 0; m_owner[b] = 0; m_pkt[b] = '0;
      end else begin
        m_pkt[b].valid = 1'b0;
        if (g[b] >= 0) begin
          r = u_if.pe_req[g[b]];
          m_pkt[b] = '{valid: 1'b1, PE_tag: PE_TAG_W'(g[b]), rd_wr: r.rd_wr,
                       Node_id: r.Node_id, data: r.data, wr_sos: r.wr_sos,
                       wr_eos: r.wr_eos};
          m_ptr[b] = (g[b] + 1) % NP;
          if (r.rd_wr) begin
            if (r.wr_sos && !r.wr_eos) begin
              m_lock[b] = 1'b1; m_owner[b] = g[b];
            end else if (m_lock[b] && r.wr_eos) begin
              m_lock[b] = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input bit wr, input int node, input logic [31:0] d,
                         input bit sos, input bit eos);
    u_if.pe_req[p].valid   = 1'b1;
    u_if.pe_req[p].rd_wr   = wr;
    u_if.pe_req[p].Node_id = NODE_W'(node);
    u_if.pe_req[p].data    = d;
    u_if.pe_req[p].wr_sos  = sos;
    u_if.pe_req[p].wr_eos  = eos;
  endtask

  task automatic clr(input int p);
    u_if.pe_req[p] = '0;
  endtask

  int rr_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    logic [NB-1:0] vbits;
    n_checks = 0;
    n_err    = 0;
    chk_en   = 1'b0;
    reset    = 1'b0;
    u_if.pe_req = '0;
    u_if.bank_available = '1;
    set_req(0, 0, 0, 32'h11, 0, 0);
    repeat (3) step();
    #2;
    chk("reset_ready", 64'(u_if.pe_req_ready), 64'h0);
    chk("reset_locked", 64'(u_if.bank_locked), 64'h0);
    chk("reset_pkt", 64'(u_if.req_pkt[0]), 64'h0);
    clr(0);
    reset  = 1'b1;
    chk_en = 1'b1;
    step();

    // Single read from PE2 to node 6 lands on bank 2.
    set_req(2, 0, 6, 32'h0, 0, 0);
    #2 chk("t1_ready", 64'(u_if.pe_req_ready), 64'b0100);
    step();
    clr(2);
    chk("t1_valid", 64'(u_if.req_pkt[2].valid), 64'd1);
    chk("t1_tag", 64'(u_if.req_pkt[2].PE_tag), 64'd2);
    chk("t1_node", 64'(u_if.req_pkt[2].Node_id), 64'd6);
    step();
    chk("t1_valid_drop", 64'(u_if.req_pkt[2].valid), 64'd0);

    // All PEs hammer bank 1: grants rotate 0,1,2,3,0.
    for (int p = 0; p < NP; p++) set_req(p, 0, 1 + 4 * p, 32'(p), 0, 0);
    for (int k = 0; k < 5; k++) begin
      #2 chk($sformatf("t2_rr%0d", k), 64'(u_if.pe_req_ready), 64'(1 << rr_order[k]));
      step();
    end
    for (int p = 0; p < NP; p++) clr(p);
    step();

    // PE1 write stream on bank 0 locks out PE3 until the cycle after eos.
    set_req(1, 1, 4, 32'hA0, 1, 0);
    set_req(3, 0, 8, 32'h0, 0, 0);
    #2 chk("t3_sos_ready", 64'(u_if.pe_req_ready), 64'b0010);
    step();
    chk("t3_locked_a", 64'(u_if.bank_locked[0]), 64'd1);
    set_req(1, 1, 4, 32'hA1, 0, 0);
    #2 chk("t3_mid_ready", 64'(u_if.pe_req_ready), 64'b0010);
    step();
    chk("t3_locked_b", 64'(u_if.bank_locked[0]), 64'd1);
    set_req(1, 1, 4, 32'hA2, 0, 1);
    #2 chk("t3_eos_ready", 64'(u_if.pe_req_ready), 64'b0010);
    step();
    clr(1);
    chk("t3_unlocked", 64'(u_if.bank_locked[0]), 64'd0);
    chk("t3_eos_pkt_data", 64'(u_if.req_pkt[0].data), 64'hA2);
    chk("t3_eos_pkt_eos", 64'(u_if.req_pkt[0].wr_eos), 64'd1);
    #2 chk("t3_pe3_ready", 64'(u_if.pe_req_ready), 64'b1000);
    step();
    clr(3);
    step();

    // Four PEs to four banks in parallel.
    for (int p = 0; p < NP; p++) set_req(p, 0, p, 32'(p * 16), 0, 0);
    #2 chk("t4_ready", 64'(u_if.pe_req_ready), 64'hF);
    step();
    for (int p = 0; p < NP; p++) clr(p);
    for (int b = 0; b < NB; b++) vbits[b] = u_if.req_pkt[b].valid;
    chk("t4_valids", 64'(vbits), 64'hF);
    step();

    // Back-pressure on bank 3 for five cycles; single-beat write never locks.
    u_if.bank_available[3] = 1'b0;
    set_req(0, 1, 3, 32'hD00D, 1, 1);
    for (int k = 0; k < 5; k++) begin
      #2 chk($sformatf("t5_stall%0d", k), 64'(u_if.pe_req_ready[0]), 64'd0);
      step();
    end
    u_if.bank_available[3] = 1'b1;
    #2 chk("t5_ready", 64'(u_if.pe_req_ready), 64'b0001);
    step();
    clr(0);
    chk("t5_data", 64'(u_if.req_pkt[3].data), 64'hD00D);
    chk("t5_tag", 64'(u_if.req_pkt[3].PE_tag), 64'd0);
    chk("t5_nolock", 64'(u_if.bank_locked[3]), 64'd0);
    step();

    // Reset during a PE2 lock on bank 1 aborts the stream.
    set_req(2, 1, 1, 32'hB0, 1, 0);
    #2 chk("t6_sos_ready", 64'(u_if.pe_req_ready), 64'b0100);
    step();
    chk("t6_locked", 64'(u_if.bank_locked[1]), 64'd1);
    set_req(2, 1, 1, 32'hB1, 0, 0);
    set_req(0, 0, 5, 32'h0, 0, 0);
    #2 chk("t6_owner_only", 64'(u_if.pe_req_ready), 64'b0100);
    reset = 1'b0;
    #1 chk("t6_reset_ready", 64'(u_if.pe_req_ready), 64'h0);
    step();
    chk("t6_locked_clr", 64'(u_if.bank_locked[1]), 64'd0);
    chk("t6_valid_clr", 64'(u_if.req_pkt[1].valid), 64'd0);
    reset = 1'b1;
    #2 chk("t6_pe0_wins", 64'(u_if.pe_req_ready), 64'b0001);
    step();
    for (int p = 0; p < NP; p++) clr(p);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
